// File: rtl/axi_reg_pkg.sv
// Shared types and constants for the AXI register slave.
// Response codes and the read/write channel state encodings.
package axi_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_reg_if.sv
// AXI burst bus between a master and the register slave.
// Slave outputs are zero when idle so siblings can be OR-combined.
interface axi_reg_if #(
  parameter int ID_W = 4
);

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    input  rready,
    output awready, wready,
    output bid, bresp, bvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    output rready,
    input  awready, wready,
    input  bid, bresp, bvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_reg_file.sv
// Register storage with byte-strobe writes.
// wr_stb pulses for one cycle alongside the updated contents.
module axi_reg_file #(
  parameter int NREGS = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] idx,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic [NREGS*32-1:0]      reg_q,
  output logic [NREGS-1:0]         wr_stb
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reg_q  <= '0;
      wr_stb <= '0;
    end else begin
      wr_stb <= '0;
      if (we) begin
        wr_stb[idx] <= 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (wstrb[j])
            reg_q[{idx, 5'd0} + j*8 +: 8] <= wdata[j*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_reg_slave.sv
// AXI burst slave exposing NREGS 32-bit registers at BASE_ADDR.
// Independent read and write FSMs; address decode lives here.
module axi_reg_slave
  import axi_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NREGS     = 16,
  parameter int          ID_W      = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi_reg_if.slave            bus,
  output logic [NREGS*32-1:0] reg_q,
  output logic [NREGS-1:0]    wr_stb
);

  localparam int          IW   = $clog2(NREGS);
  localparam logic [31:0] MASK = ~(32'(NREGS*4) - 32'd1);

  wr_state_t wr_st, wr_st_n;
  rd_state_t rd_st, rd_st_n;

  logic [ID_W-1:0] wr_id, rd_id;
  logic [IW-1:0]   wr_idx, rd_idx, rd_nidx;
  logic [7:0]      wr_len, wr_cnt, rd_len, rd_cnt;
  logic [1:0]      bresp_q;
  logic [31:0]     rdata_q;
  logic            aw_hit, ar_hit;
  logic            wr_beat, wr_done, rd_beat, rd_done;

  assign aw_hit  = (bus.awaddr & MASK) == BASE_ADDR;
  assign ar_hit  = (bus.araddr & MASK) == BASE_ADDR;
  assign wr_beat = (wr_st == W_DATA) && bus.wvalid;
  assign wr_done = wr_beat && (wr_cnt == wr_len);
  assign rd_beat = (rd_st == R_DATA) && bus.rready;
  assign rd_done = rd_beat && (rd_cnt == rd_len);
  assign rd_nidx = rd_idx + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_st <= W_IDLE;
      rd_st <= R_IDLE;
    end else begin
      wr_st <= wr_st_n;
      rd_st <= rd_st_n;
    end
  end

  always_comb begin
    wr_st_n = wr_st;
    unique case (wr_st)
      W_IDLE:  if (bus.awvalid && aw_hit) wr_st_n = W_ADDR;
      W_ADDR:  wr_st_n = W_DATA;
      W_DATA:  if (wr_done) wr_st_n = W_RESP;
      W_RESP:  if (bus.bready) wr_st_n = W_IDLE;
      default: wr_st_n = W_IDLE;
    endcase
  end

  always_comb begin
    rd_st_n = rd_st;
    unique case (rd_st)
      R_IDLE:  if (bus.arvalid && ar_hit) rd_st_n = R_ADDR;
      R_ADDR:  rd_st_n = R_DATA;
      R_DATA:  if (rd_done) rd_st_n = R_IDLE;
      default: rd_st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_id   <= '0;
      wr_idx  <= '0;
      wr_len  <= '0;
      wr_cnt  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (wr_st == W_IDLE && bus.awvalid && aw_hit) begin
        wr_id  <= bus.awid;
        wr_idx <= bus.awaddr[2 +: IW];
        wr_len <= bus.awlen;
        wr_cnt <= '0;
      end
      if (wr_beat) begin
        wr_idx <= wr_idx + 1'b1;
        wr_cnt <= wr_cnt + 8'd1;
      end
      if (wr_done)
        bresp_q <= bus.wlast ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // rdata samples the pre-write contents when a write lands on the same edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_id   <= '0;
      rd_idx  <= '0;
      rd_len  <= '0;
      rd_cnt  <= '0;
      rdata_q <= '0;
    end else begin
      if (rd_st == R_IDLE && bus.arvalid && ar_hit) begin
        rd_id  <= bus.arid;
        rd_idx <= bus.araddr[2 +: IW];
        rd_len <= bus.arlen;
        rd_cnt <= '0;
      end
      if (rd_st == R_ADDR)
        rdata_q <= reg_q[{rd_idx, 5'd0} +: 32];
      if (rd_beat && !rd_done) begin
        rd_idx  <= rd_nidx;
        rd_cnt  <= rd_cnt + 8'd1;
        rdata_q <= reg_q[{rd_nidx, 5'd0} +: 32];
      end
    end
  end

  assign bus.awready = (wr_st == W_ADDR);
  assign bus.wready  = (wr_st == W_DATA);
  assign bus.bvalid  = (wr_st == W_RESP);
  assign bus.bid     = bus.bvalid ? wr_id : '0;
  assign bus.bresp   = bus.bvalid ? bresp_q : RESP_OKAY;

  assign bus.arready = (rd_st == R_ADDR);
  assign bus.rvalid  = (rd_st == R_DATA);
  assign bus.rid     = bus.rvalid ? rd_id : '0;
  assign bus.rdata   = bus.rvalid ? rdata_q : '0;
  assign bus.rresp   = RESP_OKAY;
  assign bus.rlast   = bus.rvalid && (rd_cnt == rd_len);

  axi_reg_file #(
    .NREGS(NREGS)
  ) u_file (
    .aclk   (aclk),
    .aresetn(aresetn),
    .we     (wr_beat),
    .idx    (wr_idx),
    .wdata  (bus.wdata),
    .wstrb  (bus.wstrb),
    .reg_q  (reg_q),
    .wr_stb (wr_stb)
  );

endmodule

// File: tb/tb_axi_reg_slave.sv
// Directed plus randomized bench for axi_reg_slave (BASE 0x100, 4 regs).
// A plain array of register words serves as the reference model.
module tb_axi_reg_slave;

  localparam logic [31:0] BASE = 32'h100;
  localparam int          N    = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_reg_if #(.ID_W(4)) bus ();
  logic [N*32-1:0] reg_q;
  logic [N-1:0]    wr_stb;

  axi_reg_slave #(
    .BASE_ADDR(BASE),
    .NREGS    (N),
    .ID_W     (4)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus),
    .reg_q  (reg_q),
    .wr_stb (wr_stb)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [N];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];
  logic        wq_last [$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] rq(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.awready, bus.wready, bus.bid, bus.bresp, bus.bvalid,
                bus.arready, bus.rid, bus.rdata, bus.rresp, bus.rlast,
                bus.rvalid});
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input int len);
    int n;
    int idx;
    int k;
    logic [1:0] exp_resp;
    idx = int'(addr[3:2]);
    bus.awid = id;
    bus.awaddr = addr;
    bus.awlen = 8'(len);
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin step(); n++; end
    check("aw_latency", 64'(n), 64'd1);
    step();
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.wdata = wq_data[b];
      bus.wstrb = wq_strb[b];
      bus.wlast = wq_last[b];
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 20) begin step(); n++; end
      check("wready_wait", 64'(n), 64'd0);
      step();
      for (int j = 0; j < 4; j++)
        if (wq_strb[b][j]) model[idx][j*8 +: 8] = wq_data[b][j*8 +: 8];
      check("wr_stb", 64'(wr_stb), 64'(1 << idx));
      check("reg_update", 64'(rq(idx)), 64'(model[idx]));
      idx = (idx + 1) % N;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    exp_resp = wq_last[len] ? 2'b00 : 2'b10;
    k = $urandom_range(0, 2);
    for (int s = 0; s < k; s++) begin
      check("bvalid_hold", 64'({bus.bvalid, bus.bid, bus.bresp}),
            64'({1'b1, id, exp_resp}));
      step();
    end
    check("bvalid", 64'(bus.bvalid), 64'd1);
    check("bid", 64'(bus.bid), 64'(id));
    check("bresp", 64'(bus.bresp), 64'(exp_resp));
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("b_done", 64'({bus.bvalid, wr_stb}), 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input int len);
    int n;
    int idx;
    int k;
    idx = int'(addr[3:2]);
    bus.arid = id;
    bus.araddr = addr;
    bus.arlen = 8'(len);
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    check("ar_latency", 64'(n), 64'd1);
    step();
    bus.arvalid = 1'b0;
    check("rvalid_latency", 64'(bus.rvalid), 64'd1);
    for (int b = 0; b <= len; b++) begin
      k = $urandom_range(0, 2);
      for (int s = 0; s <= k; s++) begin
        if (s == k) bus.rready = 1'b1;
        check("rvalid", 64'(bus.rvalid), 64'd1);
        check("rdata", 64'(bus.rdata), 64'(model[idx]));
        check("rlast", 64'(bus.rlast), 64'(b == len));
        check("rid_rresp", 64'({bus.rid, bus.rresp}), 64'({id, 2'b00}));
        step();
      end
      bus.rready = 1'b0;
      idx = (idx + 1) % N;
    end
    check("r_done", 64'(bus.rvalid), 64'd0);
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s,
                           input logic l);
    wq_data.push_back(d);
    wq_strb.push_back(s);
    wq_last.push_back(l);
  endtask

  task automatic clear_q();
    wq_data.delete();
    wq_strb.delete();
    wq_last.delete();
  endtask

  initial begin
    int n;
    int len;
    logic [31:0] old_v;
    logic [31:0] new_v;
    for (int i = 0; i < N; i++) model[i] = '0;
    {bus.awid, bus.awaddr, bus.awlen, bus.awvalid} = '0;
    {bus.wdata, bus.wstrb, bus.wlast, bus.wvalid, bus.bready} = '0;
    {bus.arid, bus.araddr, bus.arlen, bus.arvalid, bus.rready} = '0;

    repeat (2) @(posedge aclk);
    #1;
    check("reset_outs", outs(), 64'd0);
    check("reset_regs", 64'(reg_q == '0), 64'd1);
    check("reset_stb", 64'(wr_stb), 64'd0);
    aresetn = 1'b1;
    for (int s = 0; s < 2; s++) begin
      step();
      check("post_reset_quiet", outs(), 64'd0);
    end

    clear_q();
    push_beat(32'hDEADBEEF, 4'hF, 1'b1);
    do_write(4'h5, 32'h108, 0);
    check("single_reg2", 64'(rq(2)), 64'hDEADBEEF);

    clear_q();
    push_beat(32'h11223344, 4'b0101, 1'b1);
    do_write(4'h3, 32'h100, 0);
    check("strobe_reg0", 64'(rq(0)), 64'h00220044);

    bus.awaddr = 32'h200;
    bus.awvalid = 1'b1;
    bus.araddr = 32'h110;
    bus.arvalid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      check("miss_quiet", outs(), 64'd0);
    end
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b0;
    check("miss_regs", 64'({rq(0), rq(2)}), 64'({32'h00220044, 32'hDEADBEEF}));

    clear_q();
    for (int b = 0; b < 4; b++) push_beat($urandom, 4'hF, b == 3);
    do_write(4'h1, BASE, 3);
    do_read(4'h9, BASE + 32'hC, 2);

    clear_q();
    push_beat($urandom, 4'hF, 1'b1);
    push_beat($urandom, 4'hF, 1'b0);
    do_write(4'h2, BASE + 32'h4, 1);

    for (int t = 0; t < 12; t++) begin
      clear_q();
      len = $urandom_range(0, 4);
      for (int b = 0; b <= len; b++)
        push_beat($urandom, 4'($urandom), (b == len) ? 1'($urandom) : 1'b0);
      do_write(4'($urandom), BASE + 32'($urandom_range(0, 15)), len);
      do_read(4'($urandom), BASE + 32'($urandom_range(0, 15)),
              $urandom_range(0, 5));
    end

    bus.awid = 4'h7;
    bus.awaddr = BASE + 32'h4;
    bus.awlen = 8'd0;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin step(); n++; end
    check("col_aw", 64'(n), 64'd1);
    step();
    bus.awvalid = 1'b0;
    bus.arid = 4'hA;
    bus.araddr = BASE;
    bus.arlen = 8'd1;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    check("col_ar", 64'(n), 64'd1);
    step();
    bus.arvalid = 1'b0;
    check("col_beat0", 64'(bus.rdata), 64'(model[0]));
    old_v = model[1];
    new_v = ~old_v;
    bus.wdata = new_v;
    bus.wstrb = 4'hF;
    bus.wlast = 1'b1;
    bus.wvalid = 1'b1;
    bus.rready = 1'b1;
    step();
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    bus.rready = 1'b0;
    model[1] = new_v;
    check("col_old_value", 64'(bus.rdata), 64'(old_v));
    check("col_rlast", 64'(bus.rlast), 64'd1);
    check("col_reg1", 64'(rq(1)), 64'(new_v));
    check("col_bvalid", 64'(bus.bvalid), 64'd1);

    #2 aresetn = 1'b0;
    #1;
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_outs", outs(), 64'd0);
    check("rst_regs", 64'(reg_q == '0), 64'd1);
    check("rst_stb", 64'(wr_stb), 64'd0);
    step();
    step();
    aresetn = 1'b1;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      check("no_stale_resp", outs(), 64'd0);
    end
    bus.bready = 1'b0;
    bus.rready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
